dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder serving the memory stage of the pipelined RV32 core.
- Accepts one load/store request per valid/ready handshake and returns a single-cycle response exactly LATENCY cycles later.
- Provides `busy` so the hazard logic can stall F/D/E/M while a request is outstanding.
- Replaces the zero-latency data memory when the core is paired with slower storage.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; word index = req_addr[31:2].
- LATENCY, 2, cycles from accept edge to rsp_valid; legal range 1..15.
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > LATENCY.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  responder can accept this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables for stores; bit i enables byte i (little-endian); ignored for loads
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  request was misaligned or out of range; valid with rsp_valid
- busy  out  1  request outstanding (state WAIT)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1.
  - Memory contents are not cleared.
  - A request in flight is dropped; no write occurs if its accept edge has not yet happened.
- States:
  - IDLE: req_ready=1. Accept on req_valid & req_ready at a rising edge.
  - WAIT: req_ready=0, busy=1.
  - RESP: rsp_valid=1 for exactly one cycle; req_ready=1.
- Accept edge:
  - Latch we, addr, wdata and be.
  - Error check: err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
  - Stores commit at the accept edge, byte-enabled, and only if !err.
  - Loads: the read value is captured at the accept edge, so a later store cannot alter the returned data.
- Transitions:
  - LATENCY=1: the accept edge goes directly to RESP.
  - LATENCY>1: the accept edge goes to WAIT with counter=LATENCY-2. WAIT decrements the counter each cycle and moves to RESP when the counter is 0.
  - RESP with a new accept: go to WAIT or RESP as above (back-to-back operation; throughput is one request per LATENCY cycles).
  - RESP with no accept: go to IDLE.
- Response contents: rsp_rdata = captured word for a load with !err, otherwise 0. rsp_err = latched err.
- A request arriving while req_ready=0 is ignored; the core must hold req_valid and its fields stable until accepted.
- req_be=0 on a store is legal: no bytes change and the response is normal.
- There is no response backpressure; the core always consumes rsp_valid.
- Outputs are registered except req_ready and busy, which are decoded from state.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds outputs stat_loads[31:0] and stat_stores[31:0], plus stat_errs[15:0].
  - Each counter increments on the accept edge of the matching request type; stat_errs counts errored requests of either type.
  - All counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - Constants WORD_BYTES=4 and ADDR_LSB=2.
  - Function is_misaligned(addr).
- Sub-module dmem_array:
  - Storage only: DEPTH_WORDS x 32 with byte-enable synchronous write and combinational read.
  - Instantiated once; the FSM, latency counter, error check and stats stay in dmem_responder.

Test Plan:
- Store then load, LATENCY=2: store addr 0x10, data 0xDEADBEEF, be=4'hF, accepted at cycle 0 -> rsp_valid at cycle 2 with rdata 0 and err 0. Load addr 0x10 -> rsp_valid 2 cycles after accept, rdata 0xDEADBEEF; busy=1 only in the intermediate cycle.
- Byte enables: word 0x20 = 0x11223344; store be=4'b0010, wdata 0xAABBCCDD -> subsequent load of 0x20 returns 0x1122CC44.
- Errors: load addr 0x13 -> rsp_err=1, rdata 0. Store to word index 1024 (addr 0x1000) -> rsp_err=1 and no array change; a following load of 0x0 returns its prior value.
- Back-to-back, LATENCY=1: req_valid held high for 3 loads -> accepted every cycle, rsp_valid high for 3 consecutive cycles with the correct data in order; busy never asserted.
- Reset mid-operation, LATENCY=3: load accepted, then rst=0 asynchronously one cycle later -> rsp_valid=0 immediately, state IDLE, req_ready=1, no response ever issued for that load. A prior store's data survives reset.
- DMEM_STATS_EN defined: 2 loads, 3 stores, 1 misaligned load -> stat_loads=3, stat_stores=3, stat_errs=1; after reset all counters are 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the multi-cycle data-memory responder.
//   state_e        : responder FSM states (IDLE / WAIT / RESP)
//   WORD_BYTES     : bytes per stored word
//   ADDR_LSB       : first address bit of the word index
//   is_misaligned  : true when a byte address is not word aligned
// ----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;

    // Only the sub-word address bits decide alignment, so only they are passed in.
    function automatic logic is_misaligned(input logic [ADDR_LSB-1:0] addr);
        return (addr != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// ----------------------------------------------------------------------------
// dmem_if
// Request/response bus between the core memory stage and the responder.
//   req_valid/req_ready : request handshake (accept when both high at clk edge)
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata/req_be    : store data and little-endian byte enables
//   rsp_valid           : one-cycle response strobe
//   rsp_rdata/rsp_err   : load data (0 for stores/errors) and error flag
//   busy                : request outstanding, used by hazard logic to stall
// Modports: master (core side), slave (responder side).
// ----------------------------------------------------------------------------
interface dmem_if;
    import dmem_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [31:0]             req_addr;
    logic [31:0]             req_wdata;
    logic [WORD_BYTES-1:0]   req_be;
    logic                    rsp_valid;
    logic [31:0]             rsp_rdata;
    logic                    rsp_err;
    logic                    busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
// Word storage for the responder: DEPTH_WORDS x 32 bits, synchronous
// byte-enabled write, combinational read. Contents are never reset.
//   clk    in  : write clock
//   wrEn   in  : commit wdata under be at this rising edge
//   idx    in  : word index used for both read and write
//   wdata  in  : store data
//   be     in  : byte enables, bit i -> byte i
//   rdata  out : current contents of word idx
// ----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [IDX_W-1:0]      idx,
    input  logic [31:0]           wdata,
    input  logic [WORD_BYTES-1:0] be,
    output logic [31:0]           rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Byte-enabled write; disabled bytes keep their previous value.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) begin
                    mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[idx];

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data-memory responder for the RV32 memory stage. Accepts one
// load/store per handshake and returns a one-cycle response exactly LATENCY
// clock edges after the accept edge. Stores commit and load data is captured
// at the accept edge, so the response never depends on later traffic.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   bus          slave side of dmem_if (request/response/busy)
//   stat_loads   out  [31:0] accepted loads        (DMEM_STATS_EN only)
//   stat_stores  out  [31:0] accepted stores       (DMEM_STATS_EN only)
//   stat_errs    out  [15:0] accepted erroneous requests (DMEM_STATS_EN only)
//
// Build option: define DMEM_STATS_EN to add the saturating request counters.
// ----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    dmem_if.slave      bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [15:0] stat_errs
`endif
);

    localparam int                IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0]       DEPTH_L  = 32'(DEPTH_WORDS);
    // Cycles spent in WAIT after the accept edge, minus the final WAIT->RESP edge.
    localparam logic [CNT_W-1:0]  CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_e           state_r;
    state_e           nextState_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] nextCnt_s;

    logic             accept_s;
    logic             reqErr_s;
    logic             wrEn_s;
    logic [31:0]      arrRdata_s;
    logic [31:0]      loadData_s;

    logic [31:0]      capData_r;
    logic             capErr_r;

    logic             rspValid_r;
    logic [31:0]      rspRdata_r;
    logic             rspErr_r;
    logic             rspValidNext_s;
    logic [31:0]      rspRdataNext_s;
    logic             rspErrNext_s;

    logic             reqReady_s;
    logic             busy_s;

    // Storage; the index is only meaningful when the request is in range,
    // and both write and capture are gated by the error check.
    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) uArray (
        .clk   (clk),
        .wrEn  (wrEn_s),
        .idx   (bus.req_addr[ADDR_LSB +: IDX_W]),
        .wdata (bus.req_wdata),
        .be    (bus.req_be),
        .rdata (arrRdata_s)
    );

    // Handshake, error check and the value a load would return if accepted now.
    always_comb begin
        accept_s = bus.req_valid & reqReady_s;
        reqErr_s = is_misaligned(bus.req_addr[ADDR_LSB-1:0]) |
                   ({2'b00, bus.req_addr[31:ADDR_LSB]} >= DEPTH_L);
        wrEn_s   = accept_s & bus.req_we & ~reqErr_s;
        if (!bus.req_we && !reqErr_s) begin
            loadData_s = arrRdata_s;
        end else begin
            loadData_s = 32'd0;
        end
    end

    // Handshake/stall decode straight from the state register.
    always_comb begin
        reqReady_s = 1'b1;
        busy_s     = 1'b0;
        case (state_r)
            IDLE:    begin reqReady_s = 1'b1; busy_s = 1'b0; end
            WAIT:    begin reqReady_s = 1'b0; busy_s = 1'b1; end
            RESP:    begin reqReady_s = 1'b1; busy_s = 1'b0; end
            default: begin reqReady_s = 1'b1; busy_s = 1'b0; end
        endcase
    end

    // Next-state and latency-counter logic.
    always_comb begin
        nextState_s = state_r;
        nextCnt_s   = cnt_r;
        case (state_r)
            IDLE, RESP: begin
                if (accept_s) begin
                    if (LATENCY == 1) begin
                        nextState_s = RESP;
                        nextCnt_s   = '0;
                    end else begin
                        nextState_s = WAIT;
                        nextCnt_s   = CNT_LOAD;
                    end
                end else begin
                    nextState_s = IDLE;
                    nextCnt_s   = cnt_r;
                end
            end
            WAIT: begin
                if (cnt_r == '0) begin
                    nextState_s = RESP;
                    nextCnt_s   = cnt_r;
                end else begin
                    nextState_s = WAIT;
                    nextCnt_s   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                nextState_s = IDLE;
                nextCnt_s   = '0;
            end
        endcase
    end

    // Response registers are loaded one edge ahead so the outputs are
    // registered; with LATENCY=1 the data bypasses the capture registers.
    always_comb begin
        rspValidNext_s = 1'b0;
        rspRdataNext_s = 32'd0;
        rspErrNext_s   = 1'b0;
        if (nextState_s == RESP) begin
            rspValidNext_s = 1'b1;
            if (accept_s) begin
                rspRdataNext_s = loadData_s;
                rspErrNext_s   = reqErr_s;
            end else begin
                rspRdataNext_s = capData_r;
                rspErrNext_s   = capErr_r;
            end
        end else begin
            rspValidNext_s = 1'b0;
            rspRdataNext_s = 32'd0;
            rspErrNext_s   = 1'b0;
        end
    end

    // State, counter, capture and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            capData_r  <= 32'd0;
            capErr_r   <= 1'b0;
            rspValid_r <= 1'b0;
            rspRdata_r <= 32'd0;
            rspErr_r   <= 1'b0;
        end else begin
            state_r    <= nextState_s;
            cnt_r      <= nextCnt_s;
            rspValid_r <= rspValidNext_s;
            rspRdata_r <= rspRdataNext_s;
            rspErr_r   <= rspErrNext_s;
            if (accept_s) begin
                capData_r <= loadData_s;
                capErr_r  <= reqErr_s;
            end
        end
    end

    assign bus.req_ready = reqReady_s;
    assign bus.busy      = busy_s;
    assign bus.rsp_valid = rspValid_r;
    assign bus.rsp_rdata = rspRdata_r;
    assign bus.rsp_err   = rspErr_r;

`ifdef DMEM_STATS_EN
    logic [31:0] statLoads_r;
    logic [31:0] statStores_r;
    logic [15:0] statErrs_r;

    // Saturating per-type request counters, stepped on the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            statLoads_r  <= 32'd0;
            statStores_r <= 32'd0;
            statErrs_r   <= 16'd0;
        end else begin
            if (accept_s && !bus.req_we && (statLoads_r != 32'hFFFF_FFFF)) begin
                statLoads_r <= statLoads_r + 32'd1;
            end
            if (accept_s && bus.req_we && (statStores_r != 32'hFFFF_FFFF)) begin
                statStores_r <= statStores_r + 32'd1;
            end
            if (accept_s && reqErr_s && (statErrs_r != 16'hFFFF)) begin
                statErrs_r <= statErrs_r + 16'd1;
            end
        end
    end

    assign stat_loads  = statLoads_r;
    assign stat_stores = statStores_r;
    assign stat_errs   = statErrs_r;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Three instances share clk/rst:
//   uL2 (LATENCY=2) : table of single requests, data/error/latency/busy
//   uL1 (LATENCY=1) : back-to-back stream, one response per cycle
//   uL3 (LATENCY=3) : reset while a load is outstanding
// With DMEM_STATS_EN defined the uL2 counters are also checked.
// ----------------------------------------------------------------------------
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nCmp = 0;
    int   nBad = 0;

    always #5 clk = ~clk;

    dmem_if ifL2 ();
    dmem_if ifL1 ();
    dmem_if ifL3 ();

`ifdef DMEM_STATS_EN
    logic [31:0] l2Loads, l2Stores, l1Loads, l1Stores, l3Loads, l3Stores;
    logic [15:0] l2Errs, l1Errs, l3Errs;
`endif

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .CNT_W(4)) uL2 (
        .clk(clk), .rst(rst), .bus(ifL2)
`ifdef DMEM_STATS_EN
        , .stat_loads(l2Loads), .stat_stores(l2Stores), .stat_errs(l2Errs)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .CNT_W(4)) uL1 (
        .clk(clk), .rst(rst), .bus(ifL1)
`ifdef DMEM_STATS_EN
        , .stat_loads(l1Loads), .stat_stores(l1Stores), .stat_errs(l1Errs)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .CNT_W(4)) uL3 (
        .clk(clk), .rst(rst), .bus(ifL3)
`ifdef DMEM_STATS_EN
        , .stat_loads(l3Loads), .stat_stores(l3Stores), .stat_errs(l3Errs)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One request on the LATENCY=2 instance, checked against its table entry.
    task automatic runL2(input vec_t v, input int idx);
        logic got;
        logic busyOk;
        int   lat;
        @(negedge clk);
        chk($sformatf("l2 idle ready[%0d]", idx), {31'd0, ifL2.req_ready}, 32'd1);
        chk($sformatf("l2 no stray rsp[%0d]", idx), {31'd0, ifL2.rsp_valid}, 32'd0);
        ifL2.req_valid = 1'b1;
        ifL2.req_we    = v.we;
        ifL2.req_addr  = v.addr;
        ifL2.req_wdata = v.wdata;
        ifL2.req_be    = v.be;
        @(posedge clk);
        #1;
        ifL2.req_valid = 1'b0;
        got = 1'b0;
        busyOk = 1'b1;
        lat = 0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk);
            if (ifL2.rsp_valid) begin
                got = 1'b1;
                lat = c;
                chk($sformatf("l2 rdata[%0d]", idx), ifL2.rsp_rdata, v.expRdata);
                chk($sformatf("l2 err[%0d]", idx), {31'd0, ifL2.rsp_err}, {31'd0, v.expErr});
                chk($sformatf("l2 busy at rsp[%0d]", idx), {31'd0, ifL2.busy}, 32'd0);
            end else if (!ifL2.busy) begin
                busyOk = 1'b0;
            end
        end
        chk($sformatf("l2 latency[%0d]", idx), 32'(lat), 32'd2);
        chk($sformatf("l2 busy in wait[%0d]", idx), {31'd0, busyOk}, 32'd1);
    endtask

    // One request on the LATENCY=3 instance; returns response data and latency.
    task automatic runL3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        ifL3.req_valid = 1'b1;
        ifL3.req_we    = we;
        ifL3.req_addr  = addr;
        ifL3.req_wdata = wdata;
        ifL3.req_be    = 4'hF;
        @(posedge clk);
        #1;
        ifL3.req_valid = 1'b0;
        lat = 0;
        rd  = 32'hX;
        er  = 1'bX;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            if (ifL3.rsp_valid) begin
                lat = c;
                rd  = ifL3.rsp_rdata;
                er  = ifL3.rsp_err;
            end
        end
    endtask

    vec_t l2Vecs[16];
    vec_t l1Vecs[6];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        seen;
        int          expLoads;
        int          expStores;
        int          expErrs;

        //              we    addr          wdata          be     expRdata       expErr
        l2Vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        l2Vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        l2Vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
        l2Vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h2, 32'h0000_0000, 1'b0};
        l2Vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h1122_CC44, 1'b0};
        l2Vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        l2Vecs[6]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
        l2Vecs[7]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1};
        l2Vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
        l2Vecs[9]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
        l2Vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
        l2Vecs[11] = '{1'b1, 32'h0000_0FFC, 32'h5A5A_0001, 4'hF, 32'h0000_0000, 1'b0};
        l2Vecs[12] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'h0, 32'h5A5A_0001, 1'b0};
        l2Vecs[13] = '{1'b1, 32'h0000_0002, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        l2Vecs[14] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
        l2Vecs[15] = '{1'b0, 32'h0000_1004, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};

        l1Vecs[0]  = '{1'b1, 32'h0000_0040, 32'hA0A0_0001, 4'hF, 32'h0000_0000, 1'b0};
        l1Vecs[1]  = '{1'b1, 32'h0000_0044, 32'hB0B0_0002, 4'hF, 32'h0000_0000, 1'b0};
        l1Vecs[2]  = '{1'b1, 32'h0000_0048, 32'hC0C0_0003, 4'hF, 32'h0000_0000, 1'b0};
        l1Vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 32'hA0A0_0001, 1'b0};
        l1Vecs[4]  = '{1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0, 32'hB0B0_0002, 1'b0};
        l1Vecs[5]  = '{1'b0, 32'h0000_0048, 32'h0000_0000, 4'h0, 32'hC0C0_0003, 1'b0};

        ifL2.req_valid = 1'b0; ifL2.req_we = 1'b0; ifL2.req_addr = 32'd0; ifL2.req_wdata = 32'd0; ifL2.req_be = 4'h0;
        ifL1.req_valid = 1'b0; ifL1.req_we = 1'b0; ifL1.req_addr = 32'd0; ifL1.req_wdata = 32'd0; ifL1.req_be = 4'h0;
        ifL3.req_valid = 1'b0; ifL3.req_we = 1'b0; ifL3.req_addr = 32'd0; ifL3.req_wdata = 32'd0; ifL3.req_be = 4'h0;

        // Reset state
        #22;
        chk("rst l2 rsp_valid", {31'd0, ifL2.rsp_valid}, 32'd0);
        chk("rst l2 rsp_rdata", ifL2.rsp_rdata, 32'd0);
        chk("rst l2 rsp_err",   {31'd0, ifL2.rsp_err}, 32'd0);
        chk("rst l2 busy",      {31'd0, ifL2.busy}, 32'd0);
        chk("rst l2 req_ready", {31'd0, ifL2.req_ready}, 32'd1);
        chk("rst l1 req_ready", {31'd0, ifL1.req_ready}, 32'd1);
        chk("rst l3 req_ready", {31'd0, ifL3.req_ready}, 32'd1);
`ifdef DMEM_STATS_EN
        chk("rst stat_loads",  l2Loads, 32'd0);
        chk("rst stat_stores", l2Stores, 32'd0);
        chk("rst stat_errs",   {16'd0, l2Errs}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // LATENCY=2 table
        expLoads = 0; expStores = 0; expErrs = 0;
        for (int i = 0; i < 16; i++) begin
            runL2(l2Vecs[i], i);
            if (l2Vecs[i].we) expStores++; else expLoads++;
            if (l2Vecs[i].expErr) expErrs++;
        end
`ifdef DMEM_STATS_EN
        chk("stat_loads",  l2Loads, 32'(expLoads));
        chk("stat_stores", l2Stores, 32'(expStores));
        chk("stat_errs",   {16'd0, l2Errs}, 32'(expErrs));
`endif

        // LATENCY=1 back-to-back stream, req_valid held high throughout
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("l1 rsp_valid[%0d]", i-1), {31'd0, ifL1.rsp_valid}, 32'd1);
                chk($sformatf("l1 rdata[%0d]", i-1), ifL1.rsp_rdata, l1Vecs[i-1].expRdata);
                chk($sformatf("l1 err[%0d]", i-1), {31'd0, ifL1.rsp_err}, 32'd0);
                chk($sformatf("l1 busy[%0d]", i-1), {31'd0, ifL1.busy}, 32'd0);
            end
            chk($sformatf("l1 ready[%0d]", i), {31'd0, ifL1.req_ready}, 32'd1);
            ifL1.req_valid = 1'b1;
            ifL1.req_we    = l1Vecs[i].we;
            ifL1.req_addr  = l1Vecs[i].addr;
            ifL1.req_wdata = l1Vecs[i].wdata;
            ifL1.req_be    = l1Vecs[i].be;
        end
        @(negedge clk);
        chk("l1 rsp_valid[5]", {31'd0, ifL1.rsp_valid}, 32'd1);
        chk("l1 rdata[5]", ifL1.rsp_rdata, l1Vecs[5].expRdata);
        ifL1.req_valid = 1'b0;
        @(negedge clk);
        chk("l1 rsp ends", {31'd0, ifL1.rsp_valid}, 32'd0);

        // LATENCY=3: store, then reset while a load is in WAIT
        runL3(1'b1, 32'h0000_0008, 32'h600D_DA7A, rd, er, lat);
        chk("l3 store latency", 32'(lat), 32'd3);
        chk("l3 store rdata", rd, 32'd0);
        @(negedge clk);
        ifL3.req_valid = 1'b1;
        ifL3.req_we    = 1'b0;
        ifL3.req_addr  = 32'h0000_0008;
        @(posedge clk);
        #1;
        ifL3.req_valid = 1'b0;
        @(negedge clk);
        chk("l3 busy before reset", {31'd0, ifL3.busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("l3 rst rsp_valid", {31'd0, ifL3.rsp_valid}, 32'd0);
        chk("l3 rst busy",      {31'd0, ifL3.busy}, 32'd0);
        chk("l3 rst req_ready", {31'd0, ifL3.req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ifL3.rsp_valid) seen = 1'b1;
        end
        chk("l3 dropped load silent", {31'd0, seen}, 32'd0);
`ifdef DMEM_STATS_EN
        chk("post-rst stat_loads",  l2Loads, 32'd0);
        chk("post-rst stat_stores", l2Stores, 32'd0);
        chk("post-rst stat_errs",   {16'd0, l2Errs}, 32'd0);
`endif
        runL3(1'b0, 32'h0000_0008, 32'h0000_0000, rd, er, lat);
        chk("l3 data survives rst", rd, 32'h600D_DA7A);
        chk("l3 load err", {31'd0, er}, 32'd0);
        chk("l3 load latency", 32'(lat), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
